// File: rtl/muldiv_hilo.sv
// ---------------------------------------------------------------------------
// muldiv_hilo
//   Multi-cycle multiply/divide unit with HI/LO result registers. It sits
//   beside the ALU in EX. A start pulse launches one of these operations:
//   MULTU, MULT, DIVU, DIV, MTHI or MTLO. HI/LO feed the MFHI/MFLO datapath.
//   Signed operations run on operand magnitudes through the unsigned
//   multiplier (multu) and the restoring divider. Signs are fixed up when
//   the result is written.
//
// Ports
//   clk_i    in   1  clock, rising edge
//   rstn_i   in   1  synchronous active-low reset
//   start_i  in   1  request, sampled only while IDLE
//   op_i     in   3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI,
//                    101 MTLO, 11x reserved (ignored)
//   a_i      in   N  operand A / dividend / MTHI-MTLO data
//   b_i      in   N  operand B / divisor
//   busy_o   out  1  high while a MUL or DIV is in flight
//   done_o   out  1  one-cycle completion pulse, HI/LO valid alongside it
//   dz_o     out  1  divide-by-zero flag, only meaningful with done_o
//   hi_o     out  N  HI register
//   lo_o     out  N  LO register
// ---------------------------------------------------------------------------

// multu: combinational unsigned N x N -> 2N multiplier core.
module multu #(
  parameter int N = 32
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};

endmodule

module muldiv_hilo #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         start_i,
  input  logic [2:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         dz_o,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  // Single-edge writes (MTHI, MTLO, divide by zero) never leave IDLE.
  // They are parked here for one edge so they complete at E1, as MUL does.
  typedef enum logic [1:0] {PEND_DZ, PEND_HI, PEND_LO} pend_t;

  state_t         state;
  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic           neg_q;
  logic           neg_r;
  logic [N-1:0]   rem;
  logic [N-1:0]   quo;
  logic [CW-1:0]  count;
  logic           pend_valid;
  pend_t          pend_op;
  logic [N-1:0]   pend_data;

  logic           op_valid;
  logic           is_signed;
  logic [N-1:0]   abs_a;
  logic [N-1:0]   abs_b;
  logic [2*N-1:0] product;
  logic [2*N-1:0] prod_res;
  logic [N:0]     shifted;
  logic           q_bit;
  logic [N-1:0]   rem_next;
  logic [N-1:0]   quo_next;
  logic [N-1:0]   div_lo;
  logic [N-1:0]   div_hi;

  assign op_valid  = !(op_i[2] && op_i[1]);
  assign is_signed = op_i[0] && !op_i[2];

  // The most-negative value has magnitude 2^(N-1). That still fits in N
  // unsigned bits, so the overflow case DIV MIN/-1 needs no special path.
  assign abs_a = (is_signed && a_i[N-1]) ? -a_i : a_i;
  assign abs_b = (is_signed && b_i[N-1]) ? -b_i : b_i;

  multu #(.N(N)) u_multu (
    .a (mag_a),
    .b (mag_b),
    .p (product)
  );

  assign prod_res = neg_q ? -product : product;

  // One restoring step: bring in the next dividend bit, subtract when it fits.
  // Because rem < divisor, a successful subtraction always fits in N bits.
  assign shifted  = {rem, quo[N-1]};
  assign q_bit    = (shifted >= {1'b0, mag_b});
  assign rem_next = q_bit ? (shifted[N-1:0] - mag_b) : shifted[N-1:0];
  assign quo_next = {quo[N-2:0], q_bit};
  assign div_lo   = neg_q ? -quo_next : quo_next;
  assign div_hi   = neg_r ? -rem_next : rem_next;

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      hi_o       <= '0;
      lo_o       <= '0;
      done_o     <= 1'b0;
      dz_o       <= 1'b0;
      mag_a      <= '0;
      mag_b      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      rem        <= '0;
      quo        <= '0;
      count      <= '0;
      pend_valid <= 1'b0;
      pend_op    <= PEND_DZ;
      pend_data  <= '0;
    end else begin
      done_o <= 1'b0;
      dz_o   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pend_valid) begin
            pend_valid <= 1'b0;
            done_o     <= 1'b1;
            unique case (pend_op)
              PEND_DZ: begin
                hi_o <= pend_data;
                lo_o <= '1;
                dz_o <= 1'b1;
              end
              PEND_HI: hi_o <= pend_data;
              PEND_LO: lo_o <= pend_data;
              default: ;
            endcase
          end
          if (start_i && op_valid) begin
            unique case (op_i)
              OP_MULTU, OP_MULT: begin
                mag_a <= abs_a;
                mag_b <= abs_b;
                neg_q <= is_signed && (a_i[N-1] ^ b_i[N-1]);
                state <= MUL;
              end
              OP_DIVU, OP_DIV: begin
                if (b_i == '0) begin
                  pend_valid <= 1'b1;
                  pend_op    <= PEND_DZ;
                  pend_data  <= a_i;
                end else begin
                  mag_b <= abs_b;
                  neg_q <= is_signed && (a_i[N-1] ^ b_i[N-1]);
                  neg_r <= is_signed && a_i[N-1];
                  rem   <= '0;
                  quo   <= abs_a;
                  count <= '0;
                  state <= DIV;
                end
              end
              OP_MTHI: begin
                pend_valid <= 1'b1;
                pend_op    <= PEND_HI;
                pend_data  <= a_i;
              end
              OP_MTLO: begin
                pend_valid <= 1'b1;
                pend_op    <= PEND_LO;
                pend_data  <= a_i;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          {hi_o, lo_o} <= prod_res;
          done_o       <= 1'b1;
          state        <= IDLE;
        end
        DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + CW'(1);
          // The Nth iteration writes the final quotient/remainder directly.
          if (count == CW'(N - 1)) begin
            lo_o   <= div_lo;
            hi_o   <= div_hi;
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
